// File: rtl/clock_set_controller.sv
// Sequencing controller for the clock's time registers: produces run-mode enables
// from the 1 Hz timebase and a debounced, auto-repeating button set mode.
module clock_set_controller #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       tick_8hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       sec_max,
  input  logic       min_max,
  output logic       en_sec,
  output logic       en_min,
  output logic       en_hr,
  output logic       sec_clear,
  output logic       military_time,
  output logic [1:0] set_mode,
  output logic       blank
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SET_FMT = 2'd3
  } state_t;

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(REPEAT_DELAY + 1);
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(REPEAT_DELAY);

  // Button vectors: bit 0 is btn_mode, bit 1 is btn_inc.
  logic [1:0]          sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]          acc_q, acc_d, press_q, press_d;
  logic [1:0][CW-1:0]  db_cnt_q, db_cnt_d;
  logic [HW-1:0]       hold_q, hold_d;
  state_t              state_q, state_d;
  logic                mil_q, mil_d;
  logic                div_q, div_d, phase_q, phase_d;
  logic                en_sec_q, en_sec_d, en_min_q, en_min_d, en_hr_q, en_hr_d;
  logic                sec_clear_q, sec_clear_d, blank_q, blank_d;
  logic                mode_press, inc_press, inc_held, rep_step, inc_evt;

  always_comb begin : front_end
    sync1_d  = {btn_inc, btn_mode};
    sync2_d  = sync1_q;
    acc_d    = acc_q;
    press_d  = '0;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == acc_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        db_cnt_d[i] = '0;
        acc_d[i]    = sync2_q[i];
        press_d[i]  = sync2_q[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin : control
    mode_press = press_q[0];
    inc_press  = press_q[1];
    inc_held   = acc_q[1];
    rep_step   = tick_8hz & inc_held & (hold_q == HOLD_MAX);
    // A mode press in the same cycle swallows any increment event.
    inc_evt    = (inc_press | rep_step) & ~mode_press;

    state_d = state_q;
    if (mode_press) begin
      unique case (state_q)
        RUN:     state_d = SET_HR;
        SET_HR:  state_d = SET_MIN;
        SET_MIN: state_d = SET_FMT;
        SET_FMT: state_d = RUN;
        default: state_d = RUN;
      endcase
    end

    hold_d = hold_q;
    if (mode_press || !inc_held) begin
      hold_d = '0;
    end else if (tick_8hz && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + 1'b1;
    end

    en_sec_d = 1'b0;
    en_min_d = 1'b0;
    en_hr_d  = 1'b0;
    mil_d    = mil_q;
    unique case (state_q)
      RUN: begin
        en_sec_d = tick_1hz;
        en_min_d = tick_1hz & sec_max;
        en_hr_d  = tick_1hz & sec_max & min_max;
      end
      SET_HR:  en_hr_d  = inc_evt;
      SET_MIN: en_min_d = inc_evt;
      SET_FMT: mil_d    = mil_q ^ (inc_press & ~mode_press);
      default: ;
    endcase

    div_d       = div_q ^ tick_8hz;
    phase_d     = phase_q ^ (tick_8hz & div_q);
    sec_clear_d = (state_d != RUN);
    blank_d     = phase_d & (state_d != RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      acc_q       <= '0;
      press_q     <= '0;
      db_cnt_q    <= '0;
      hold_q      <= '0;
      state_q     <= RUN;
      mil_q       <= 1'b0;
      div_q       <= 1'b0;
      phase_q     <= 1'b0;
      en_sec_q    <= 1'b0;
      en_min_q    <= 1'b0;
      en_hr_q     <= 1'b0;
      sec_clear_q <= 1'b0;
      blank_q     <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      acc_q       <= acc_d;
      press_q     <= press_d;
      db_cnt_q    <= db_cnt_d;
      hold_q      <= hold_d;
      state_q     <= state_d;
      mil_q       <= mil_d;
      div_q       <= div_d;
      phase_q     <= phase_d;
      en_sec_q    <= en_sec_d;
      en_min_q    <= en_min_d;
      en_hr_q     <= en_hr_d;
      sec_clear_q <= sec_clear_d;
      blank_q     <= blank_d;
    end
  end

  assign en_sec        = en_sec_q;
  assign en_min        = en_min_q;
  assign en_hr         = en_hr_q;
  assign sec_clear     = sec_clear_q;
  assign military_time = mil_q;
  assign set_mode      = state_q;
  assign blank         = blank_q;

endmodule
